// File: rtl/memory_issue_scheduler.sv
// Issue stage merging controller instructions and FMA write-back stores into memory's single instruction port.
// Optional MEM_SCHED_STATS_EN adds a saturating hazard/back-pressure stall counter output.
module memory_issue_scheduler #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_LENGTH       = 9,
    parameter int BRAM_LATENCY      = 2,
    parameter int WB_BURST_MAX      = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [INSTRUCTION_WIDTH-1:0] ctrl_instr_in,
    input  logic                         ctrl_valid_in,
    output logic                         ctrl_ready_out,
    input  logic [ADDR_LENGTH-1:0]       wb_addr_in,
    input  logic                         wb_valid_in,
    output logic                         wb_ready_out,
    input  logic                         flush_in,
    output logic                         flush_done_out,
`ifdef MEM_SCHED_STATS_EN
    output logic [15:0]                  stall_count_out,
`endif
    output logic [INSTRUCTION_WIDTH-1:0] instr_out,
    output logic                         instr_valid_out
);

    localparam int BURST_W = $clog2(WB_BURST_MAX + 1);

    localparam logic [3:0] OP_NOP          = 4'b0000;
    localparam logic [3:0] OP_STORE_WB     = 4'b1010;
    localparam logic [3:0] OP_LOAD_LINE    = 4'b1100;
    localparam logic [3:0] OP_WRITE_COMMIT = 4'b1110;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [BURST_W-1:0] sat_inc_burst(input logic [BURST_W-1:0] v);
        return (v >= BURST_W'(WB_BURST_MAX)) ? v : v + BURST_W'(1);
    endfunction

    state_t                         state, state_next;
    logic [BURST_W-1:0]             burst_cnt, burst_next;
    logic [BRAM_LATENCY-1:0]        sb_valid;
    logic [ADDR_LENGTH-1:0]         sb_addr [BRAM_LATENCY];

    logic [3:0]                     ctrl_op;
    logic [ADDR_LENGTH-1:0]         ctrl_addr;
    logic [INSTRUCTION_WIDTH-1:0]   wb_instr;
    logic                           sb_hit;
    logic                           hazard;
    logic                           blocked;
    logic                           ctrl_eligible;
    logic                           burst_full;
    logic                           wb_grant;
    logic                           ctrl_grant;
    logic                           push_valid;
    logic [ADDR_LENGTH-1:0]         push_addr;
    logic                           sb_drained;
    logic                           done_next;

    logic [INSTRUCTION_WIDTH-1:0]   instr_p1;
    logic                           vld_p1;
    logic                           done_p1;

    assign ctrl_op   = ctrl_instr_in[31:28];
    assign ctrl_addr = ctrl_instr_in[ADDR_LENGTH+7:8];

    always_comb begin
        wb_instr        = '0;
        wb_instr[31:28] = OP_STORE_WB;
        wb_instr[23:8]  = 16'(wb_addr_in);
    end

    // Stage p0: hazard lookup and arbitration
    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            if (sb_valid[i] && (sb_addr[i] == ctrl_addr)) begin
                sb_hit = 1'b1;
            end
        end
    end

    assign hazard        = ctrl_valid_in && (ctrl_op == OP_LOAD_LINE) && sb_hit;
    assign blocked       = !rst_in || flush_in || (state == S_DRAIN);
    assign ctrl_eligible = ctrl_valid_in && !hazard;
    assign burst_full    = (burst_cnt >= BURST_W'(WB_BURST_MAX));
    assign wb_grant      = !blocked && wb_valid_in && !(burst_full && ctrl_eligible);
    assign ctrl_grant    = !blocked && !wb_grant && ctrl_eligible;

    assign ctrl_ready_out = ctrl_grant;
    assign wb_ready_out   = wb_grant;

    assign push_valid = wb_grant ||
                        (ctrl_grant && ((ctrl_op == OP_WRITE_COMMIT) || (ctrl_op == OP_STORE_WB)));
    assign push_addr  = wb_grant ? wb_addr_in : ctrl_addr;

    // Empty after this edge's shift: nothing pushed and no entry survives into the next slot
    always_comb begin
        sb_drained = !push_valid;
        for (int i = 0; i < BRAM_LATENCY - 1; i++) begin
            if (sb_valid[i]) begin
                sb_drained = 1'b0;
            end
        end
    end

    always_comb begin
        burst_next = burst_cnt;
        if (ctrl_grant || !ctrl_valid_in) begin
            burst_next = '0;
        end else if (wb_grant) begin
            burst_next = sat_inc_burst(burst_cnt);
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            S_RUN, S_STALL: begin
                if (flush_in) begin
                    if (sb_drained && !done_p1) begin
                        done_next  = 1'b1;
                        state_next = S_RUN;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end else if (hazard) begin
                    state_next = S_STALL;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (sb_drained) begin
                    done_next  = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_RUN;
            burst_cnt <= '0;
            sb_valid  <= '0;
        end else begin
            state       <= state_next;
            burst_cnt   <= burst_next;
            sb_valid[0] <= push_valid;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                sb_valid[i] <= sb_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        sb_addr[0] <= push_addr;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            sb_addr[i] <= sb_addr[i-1];
        end
    end

    // Stage p1: registered issue toward memory
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            done_p1 <= done_next;
            if (wb_grant) begin
                instr_p1 <= wb_instr;
                vld_p1   <= 1'b1;
            end else if (ctrl_grant && (ctrl_op != OP_NOP)) begin
                instr_p1 <= ctrl_instr_in;
                vld_p1   <= 1'b1;
            end else begin
                instr_p1 <= '0;
                vld_p1   <= 1'b0;
            end
        end
    end

    assign instr_out       = instr_p1;
    assign instr_valid_out = vld_p1;
    assign flush_done_out  = done_p1;

`ifdef MEM_SCHED_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (ctrl_valid_in && !ctrl_ready_out) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

    assign stall_count_out = stall_cnt;
`endif

endmodule

// File: tb/tb_memory_issue_scheduler.sv
// Randomized bench for memory_issue_scheduler against a cycle-history reference model, plus pinned scenarios.
module tb_memory_issue_scheduler;

    localparam int IW = 32;
    localparam int AL = 9;
    localparam int BL = 2;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] ctrl_instr;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [AL-1:0] wb_addr;
    logic          wb_valid;
    logic          wb_ready;
    logic          flush;
    logic          flush_done;
    logic [IW-1:0] instr;
    logic          instr_valid;
`ifdef MEM_SCHED_STATS_EN
    logic [15:0]   stall_count;
`endif

    always #5 clk = ~clk;

    memory_issue_scheduler #(
        .INSTRUCTION_WIDTH(IW), .ADDR_LENGTH(AL), .BRAM_LATENCY(BL), .WB_BURST_MAX(BM)
    ) dut (
        .clk_in(clk), .rst_in(rst_n),
        .ctrl_instr_in(ctrl_instr), .ctrl_valid_in(ctrl_valid), .ctrl_ready_out(ctrl_ready),
        .wb_addr_in(wb_addr), .wb_valid_in(wb_valid), .wb_ready_out(wb_ready),
        .flush_in(flush), .flush_done_out(flush_done),
`ifdef MEM_SCHED_STATS_EN
        .stall_count_out(stall_count),
`endif
        .instr_out(instr), .instr_valid_out(instr_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tick    = 0;

    typedef struct {
        int            cyc;
        logic [AL-1:0] addr;
    } wr_t;

    // Reference model: every write issued, with the cycle of its handshake
    wr_t           wq[$];
    int            m_burst;
    bit            m_drain;
    bit            m_done;
    logic [IW-1:0] m_instr;
    bit            m_valid;
    bit            m_cr;
    bit            m_wr;
    int            m_stalls;
    bit            acc_c;
    bit            acc_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @tick %0d: got %h, expected %h", name, tick, act, exp);
        end
    endtask

    function automatic bit write_in(input logic [AL-1:0] a, input int lo, input int hi, input bit any);
        foreach (wq[i]) begin
            if (wq[i].cyc >= lo && wq[i].cyc <= hi && (any || wq[i].addr == a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        wq.delete();
        m_burst  = 0;
        m_drain  = 0;
        m_done   = 0;
        m_instr  = '0;
        m_valid  = 0;
        m_stalls = 0;
    endtask

    // One clock: entered just after a negedge with inputs set, leaves at the next negedge
    task automatic step();
        logic [3:0]    op;
        logic [AL-1:0] ca;
        bit            haz, ce, blocked, empty, new_done;
        #1;
        op      = ctrl_instr[31:28];
        ca      = ctrl_instr[AL+7:8];
        haz     = ctrl_valid && (op == 4'hC) && write_in(ca, tick - BL, tick - 1, 1'b0);
        ce      = ctrl_valid && !haz;
        blocked = m_drain || flush;
        m_wr    = !blocked && wb_valid && !(m_burst >= BM && ce);
        m_cr    = !blocked && !m_wr && ce;
        chk("ctrl_ready", ctrl_ready, m_cr);
        chk("wb_ready", wb_ready, m_wr);
        acc_c = m_cr;
        acc_w = m_wr;
        if (ctrl_valid && !m_cr && m_stalls < 16'hFFFF) m_stalls++;

        @(posedge clk);
        if (m_wr) begin
            m_instr = {4'hA, 4'h0, 16'(wb_addr), 8'h00};
            m_valid = 1;
            wq.push_back('{tick, wb_addr});
        end else if (m_cr) begin
            m_valid = (op != 4'h0);
            m_instr = m_valid ? ctrl_instr : '0;
            if (op == 4'hE || op == 4'hA) wq.push_back('{tick, ca});
        end else begin
            m_instr = '0;
            m_valid = 0;
        end
        if (m_cr || !ctrl_valid) m_burst = 0;
        else if (m_wr && m_burst < BM) m_burst++;
        empty    = !write_in('0, tick + 1 - BL, tick, 1'b1);
        new_done = 0;
        if (m_drain) begin
            if (empty) begin
                new_done = 1;
                m_drain  = 0;
            end
        end else if (flush) begin
            if (empty && !m_done) new_done = 1;
            else m_drain = 1;
        end
        m_done = new_done;
        while (wq.size() > 0 && wq[0].cyc < tick - BL - 2) void'(wq.pop_front());
        tick++;

        #1;
        chk("instr_out", instr, m_instr);
        chk("instr_valid", instr_valid, m_valid);
        chk("flush_done", flush_done, m_done);
`ifdef MEM_SCHED_STATS_EN
        chk("stall_count", stall_count, m_stalls);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_ctrl_ready", ctrl_ready, 0);
            chk("rst_wb_ready", wb_ready, 0);
            chk("rst_instr", instr, 0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_done", flush_done, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        ctrl_valid = 0;
        wb_valid   = 0;
        flush      = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [AL-1:0] rand_addr();
        case ($urandom_range(0, 6))
            0: return 9'd0;
            1: return 9'd1;
            2: return 9'd2;
            3: return 9'd3;
            4: return 9'd8;
            5: return 9'd9;
            default: return AL'($urandom);
        endcase
    endfunction

    function automatic logic [IW-1:0] rand_ctrl();
        logic [3:0] ops [7];
        ops = '{4'h0, 4'h7, 4'hE, 4'hA, 4'hC, 4'hC, 4'hD};
        return {ops[$urandom_range(0, 6)], 4'($urandom), 7'($urandom), rand_addr(), 8'($urandom)};
    endfunction

    initial begin
        int ta, tries, ctrl_idx, wb_before, flush_cnt;
        ctrl_instr = '0;
        ctrl_valid = 1;
        wb_addr    = 9'h011;
        wb_valid   = 1;
        flush      = 0;
        rst_n      = 0;
        ctrl_instr = 32'h1D00_0100;
        do_reset(3);

        // First handshake after reset: write-back wins, controller waits
        step();
        chk("first_wb_grant", {31'd0, acc_w}, 1);
        chk("first_issue", instr, 32'hA000_1100);
        wb_valid = 0;
        step();
        chk("passthrough", instr, 32'h1D00_0100);
        chk("passthrough_vld", instr_valid, 1);
        idle(4);

        // Load to a just-written line waits out the BRAM latency
        wb_valid = 1;
        wb_addr  = 9'd8;
        step();
        chk("hazard_store", instr, 32'hA000_0800);
        ta         = tick;
        wb_valid   = 0;
        ctrl_valid = 1;
        ctrl_instr = 32'hC000_0800;
        tries      = 0;
        do begin
            step();
            tries++;
        end while (!acc_c && tries < 10);
        ctrl_valid = 0;
        chk("hazard_load", instr, 32'hC000_0800);
        chk("hazard_gap", tick - ta, BL + 1);
        chk("hazard_tries", tries, BL + 1);
        idle(4);

        wb_valid = 1;
        wb_addr  = 9'd8;
        step();
        wb_valid   = 0;
        ctrl_valid = 1;
        ctrl_instr = 32'hC000_0900;
        step();
        chk("other_line_ready", {31'd0, acc_c}, 1);
        chk("other_line_issue", instr, 32'hC000_0900);
        idle(4);

        // Starvation guard
        ctrl_valid = 1;
        ctrl_instr = 32'hD300_0000;
        wb_valid   = 1;
        ctrl_idx   = -1;
        wb_before  = 0;
        for (int i = 0; i < 6; i++) begin
            wb_addr = AL'(9'd20 + i);
            step();
            if (acc_c && ctrl_idx < 0) begin
                ctrl_idx   = i;
                ctrl_valid = 0;
            end
            if (acc_w && ctrl_idx < 0) wb_before++;
        end
        chk("starve_ctrl_slot", ctrl_idx, BM);
        chk("starve_wb_before", wb_before, BM);
        chk("starve_wb_resume", {31'd0, acc_w}, 1);
        idle(4);

        // Flush with a write in flight
        ctrl_valid = 1;
        ctrl_instr = 32'hE000_0300;
        step();
        chk("flush_write_acc", {31'd0, acc_c}, 1);
        ctrl_instr = 32'hD000_0000;
        wb_valid   = 1;
        wb_addr    = 9'd5;
        flush      = 1;
        step();
        chk("drain1_readies", {30'd0, ctrl_ready, wb_ready}, 0);
        chk("drain1_done", flush_done, 0);
        chk("drain1_valid", instr_valid, 0);
        step();
        chk("drain2_done", flush_done, 1);
        chk("drain2_valid", instr_valid, 0);
        flush = 0;
        step();
        chk("after_drain_done", flush_done, 0);
        chk("after_drain_issue", instr, 32'hA000_0500);
        idle(4);
        flush = 1;
        step();
        chk("empty_flush_done", flush_done, 1);
        flush = 0;
        step();
        chk("empty_flush_pulse", flush_done, 0);
        idle(3);

        // Randomized traffic with occasional flushes and resets
        flush_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ctrl_valid || acc_c) begin
                ctrl_valid = ($urandom_range(0, 2) != 0);
                ctrl_instr = rand_ctrl();
            end
            if (!wb_valid || acc_w) begin
                wb_valid = $urandom_range(0, 1);
                wb_addr  = rand_addr();
            end
            if (flush_cnt > 0) flush_cnt--;
            else if ($urandom_range(0, 39) == 0) flush_cnt = $urandom_range(1, 4);
            flush = (flush_cnt > 0);
            acc_c = 0;
            acc_w = 0;
            if (i % 1000 == 999) do_reset(2);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
